uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_rx_pkt_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes as SYNC / LEN / payload / XOR-checksum packets and holds each
// good packet in a readable buffer until the consumer acknowledges it.
module uart_rx_pkt_ctrl #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned MAX_LEN        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       rx_ready_clear,
   output logic       pkt_valid,
   output logic [4:0] pkt_len,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       pkt_ack,
   output logic       err_csum,
   output logic       err_len,
   output logic       err_timeout
);

   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, HOLD} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_clr;
   logic        r_valid;
   logic        r_err_csum;
   logic        r_err_len;
   logic        r_err_to;
   logic [4:0]  r_len;
   logic [4:0]  r_pkt_len;
   logic [3:0]  r_idx;
   logic [7:0]  r_xor;
   logic [16:0] r_tcnt;
   logic [7:0]  r_buf [16];

   logic        w_in_pkt;
   logic        w_consume;
   logic        w_timeout;
   logic        w_len_ok;
   logic        w_last;
   logic        w_csum_ok;
   logic        w_set_valid;
   logic        w_set_err_len;
   logic        w_set_err_csum;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_state <= HUNT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = HUNT;
      end else begin
         case (r_state)
            HUNT:    if (w_consume && (rx_data == SYNC_BYTE)) w_state_nxt = LEN;
            LEN:     if (w_consume) w_state_nxt = w_len_ok ? PAYLOAD : HUNT;
            PAYLOAD: if (w_consume && w_last) w_state_nxt = CSUM;
            CSUM:    if (w_consume) w_state_nxt = w_csum_ok ? HOLD : HUNT;
            HOLD:    if (pkt_ack) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   // A byte consumed on the expiry edge takes priority over the timeout.
   always_comb begin
      w_in_pkt       = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CSUM);
      w_consume      = rx_ready && !r_clr && (r_state != HOLD);
      w_timeout      = w_in_pkt && !w_consume && (r_tcnt == 17'(TIMEOUT_CYCLES - 1));
      w_len_ok       = (rx_data != '0) && (rx_data <= 8'(MAX_LEN));
      w_last         = ({1'b0, r_idx} == (r_len - 5'd1));
      w_csum_ok      = (rx_data == r_xor);
      w_set_err_len  = w_consume && (r_state == LEN)  && !w_len_ok;
      w_set_err_csum = w_consume && (r_state == CSUM) && !w_csum_ok;
      w_set_valid    = w_consume && (r_state == CSUM) && w_csum_ok;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr      <= 1'b0;
         r_valid    <= 1'b0;
         r_pkt_len  <= '0;
         r_err_csum <= 1'b0;
         r_err_len  <= 1'b0;
         r_err_to   <= 1'b0;
         r_len      <= '0;
         r_idx      <= '0;
         r_xor      <= '0;
         r_tcnt     <= '0;
      end else begin
         r_err_len  <= w_set_err_len;
         r_err_csum <= w_set_err_csum;
         r_err_to   <= w_timeout;

         if (w_consume)     r_clr <= 1'b1;
         else if (!rx_ready) r_clr <= 1'b0;

         if (!w_in_pkt || w_consume || w_timeout) r_tcnt <= '0;
         else                                     r_tcnt <= r_tcnt + 17'd1;

         if (w_consume && (r_state == LEN) && w_len_ok) begin
            r_len <= rx_data[4:0];
            r_xor <= rx_data;
            r_idx <= '0;
         end
         if (w_consume && (r_state == PAYLOAD)) begin
            r_xor <= r_xor ^ rx_data;
            r_idx <= r_idx + 4'd1;
         end

         if (w_set_valid) begin
            r_valid   <= 1'b1;
            r_pkt_len <= r_len;
         end else if ((r_state == HOLD) && pkt_ack) begin
            r_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_consume && (r_state == PAYLOAD)) r_buf[r_idx] <= rx_data;
   end

   assign rx_ready_clear = r_clr;
   assign pkt_valid      = r_valid;
   assign pkt_len        = r_pkt_len;
   assign rd_data        = r_buf[rd_addr];
   assign err_csum       = r_err_csum;
   assign err_len        = r_err_len;
   assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Randomized bench for uart_rx_pkt_ctrl against a byte-stream packet parser model.
module tb_uart_rx_pkt_ctrl;
   localparam int TO = 50;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_ready = 1'b0;
   logic       rx_ready_clear;
   logic       pkt_valid;
   logic [4:0] pkt_len;
   logic [3:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       pkt_ack = 1'b0;
   logic       err_csum;
   logic       err_len;
   logic       err_timeout;

   uart_rx_pkt_ctrl #(
      .SYNC_BYTE(8'hA5),
      .MAX_LEN(16),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_ready(rx_ready),
      .rx_ready_clear(rx_ready_clear),
      .pkt_valid(pkt_valid),
      .pkt_len(pkt_len),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .pkt_ack(pkt_ack),
      .err_csum(err_csum),
      .err_len(err_len),
      .err_timeout(err_timeout)
   );

   always #20 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 0;
   int n_csum = 0, n_len = 0, n_to = 0;
   int exp_csum = 0, exp_len = 0, exp_to = 0;
   int to_cyc = -1;

   // Parser model: in-packet flag, length (0 = awaiting length byte), payload queue.
   bit         m_in_pkt = 0;
   bit         m_hold = 0;
   int         m_L = 0;
   logic [7:0] m_pl[$];
   int         m_last_cons = 0;

   always @(posedge sys_clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge sys_clk) begin
      if (mon_en && rst_n) begin
         n_csum += int'(err_csum);
         n_len  += int'(err_len);
         n_to   += int'(err_timeout);
         if (err_timeout) to_cyc = cyc;
         if (int'(err_csum) + int'(err_len) + int'(err_timeout) > 1)
            check_eq("err_onehot", int'(err_csum) + int'(err_len) + int'(err_timeout), 1);
      end
   end

   function automatic logic [7:0] model_xor();
      logic [7:0] x = 8'(m_L);
      foreach (m_pl[i]) x ^= m_pl[i];
      return x;
   endfunction

   function automatic void model_byte(input logic [7:0] b, input int k);
      if (m_in_pkt && k > TO) begin
         exp_to++;
         m_in_pkt = 0;
      end
      if (!m_in_pkt) begin
         if (b == 8'hA5) begin
            m_in_pkt = 1;
            m_L = 0;
         end
      end else if (m_L == 0) begin
         if (b >= 1 && b <= 16) begin
            m_L = int'(b);
            m_pl.delete();
         end else begin
            exp_len++;
            m_in_pkt = 0;
         end
      end else if (m_pl.size() < m_L) begin
         m_pl.push_back(b);
      end else begin
         if (b == model_xor()) m_hold = 1;
         else exp_csum++;
         m_in_pkt = 0;
      end
   endfunction

   task automatic check_errs();
      check_eq("n_err_csum", n_csum, exp_csum);
      check_eq("n_err_len", n_len, exp_len);
      check_eq("n_err_timeout", n_to, exp_to);
   endtask

   task automatic check_payload(input string tag);
      check_eq({tag, "_len"}, pkt_len, m_L);
      for (int i = 0; i < m_L; i++) begin
         rd_addr = 4'(i);
         #1;
         check_eq({tag, "_data"}, rd_data, m_pl[i]);
      end
   endtask

   // Called at the negedge where rx_ready is already up; the DUT consumes on the next posedge.
   task automatic finish_byte(input logic [7:0] b, input int h);
      int k = cyc + 1 - m_last_cons;
      m_last_cons = cyc + 1;
      model_byte(b, k);
      for (int i = 0; i < h; i++) begin
         @(negedge sys_clk);
         check_eq("clr_set", rx_ready_clear, 1);
      end
      rx_ready = 1'b0;
      @(negedge sys_clk);
      check_eq("clr_drop", rx_ready_clear, 0);
      check_errs();
      check_eq("valid", pkt_valid, m_hold);
      if (m_hold) check_payload("pkt");
   endtask

   task automatic send(input logic [7:0] b, input int g, input int h);
      for (int i = 0; i < g; i++) begin
         @(negedge sys_clk);
         pkt_ack = !m_hold && ($urandom_range(0, 7) == 0);
      end
      @(negedge sys_clk);
      pkt_ack  = 1'b0;
      rx_data  = b;
      rx_ready = 1'b1;
      if (m_hold) begin
         int w = $urandom_range(1, 3);
         for (int i = 0; i < w; i++) begin
            @(negedge sys_clk);
            check_eq("hold_clr", rx_ready_clear, 0);
            check_eq("hold_valid", pkt_valid, 1);
         end
         check_payload("hold");
         pkt_ack = 1'b1;
         @(negedge sys_clk);
         pkt_ack = 1'b0;
         check_eq("ack_valid", pkt_valid, 0);
         check_eq("ack_clr", rx_ready_clear, 0);
         m_hold = 0;
      end
      finish_byte(b, h);
   endtask

   task automatic do_reset(input bit keep_ready);
      @(negedge sys_clk);
      pkt_ack  = 1'b0;
      rx_data  = 8'hA5;
      rx_ready = keep_ready;
      rst_n    = 1'b0;
      #1;
      check_eq("rst_clr", rx_ready_clear, 0);
      check_eq("rst_valid", pkt_valid, 0);
      check_eq("rst_len", pkt_len, 0);
      check_eq("rst_errs", {err_csum, err_len, err_timeout}, 0);
      m_in_pkt = 0;
      m_hold   = 0;
      repeat (2) @(negedge sys_clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      if (keep_ready) finish_byte(8'hA5, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
      if (m_in_pkt && cyc >= m_last_cons + TO) begin
         exp_to++;
         m_in_pkt = 0;
      end
      check_errs();
   endtask

   task automatic send_list(input logic [7:0] q[$]);
      foreach (q[i]) send(q[i], 0, 1);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [7:0] q[$];
      bit long_next;

      do_reset(0);

      // Checksum covers the length byte and every payload byte.
      send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
      send_list('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
      send_list('{8'hA5, 8'h01, 8'h7F, 8'h7E});
      send_list('{8'hA5, 8'h00, 8'hA5, 8'h11});

      to_cyc = -1;
      send_list('{8'hA5, 8'h04, 8'h01});
      idle(TO + 10);
      check_eq("timeout_latency", 32'(to_cyc - m_last_cons), TO);

      send_list('{8'hA5, 8'h01, 8'hA5, 8'hA4});
      send_list('{8'h55, 8'hA5, 8'h01, 8'hA5, 8'hA4});

      send(8'hA5, 0, 5);
      send(8'h02, 0, 5);
      send(8'h33, 2, 5);
      send(8'h44, 0, 5);
      send(8'h02 ^ 8'h33 ^ 8'h44, 0, 1);

      // Inter-byte distance 50 survives, 51 expires.
      send(8'hA5, 0, 1);
      send(8'h02, 0, 1);
      send(8'h10, TO - 3, 1);
      send(8'h20, TO - 2, 1);

      send_list('{8'hA5, 8'h03, 8'h01});
      do_reset(1);
      send_list('{8'h02, 8'hAA, 8'hBB, 8'h02 ^ 8'hAA ^ 8'hBB});

      long_next = 0;
      for (int p = 0; p < 150; p++) begin
         int kind = $urandom_range(0, 9);
         int L;
         logic [7:0] x;
         q.delete();
         if (kind <= 5 || kind == 8) begin
            L = $urandom_range(1, 16);
            x = 8'(L);
            q.push_back(8'hA5);
            q.push_back(8'(L));
            for (int i = 0; i < L; i++) begin
               logic [7:0] d = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
               q.push_back(d);
               x ^= d;
            end
            if (kind == 5) x ^= 8'(1 << $urandom_range(0, 7));
            if (kind == 8) void'(q.pop_back());
            else q.push_back(x);
         end else if (kind == 6) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) q.push_back(8'($urandom));
         end else if (kind == 7) begin
            q.push_back(8'hA5);
            q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
         end else begin
            q.push_back(8'hA5);
            q.push_back(8'($urandom_range(2, 16)));
            q.push_back(8'($urandom));
         end
         foreach (q[i]) begin
            int g = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 5, TO - 1) : $urandom_range(0, 3);
            if (long_next) g = $urandom_range(TO, TO + 10);
            long_next = 0;
            send(q[i], g, $urandom_range(1, 3));
         end
         if (kind == 8) long_next = 1;
         if (kind == 9) do_reset(1'($urandom_range(0, 1)));
      end

      idle(TO + 5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
